// File: rtl/pe_pkg.sv
// Shared PE arithmetic helpers: sign extension and saturating addition on a
// 64-bit working width, plus the default accumulator width used by PE blocks.
package pe_pkg;

  localparam int PE_ACC_WIDTH = 40;
  localparam int PE_MAXW      = 64;

  typedef logic signed [PE_MAXW-1:0] pe_wide_t;

  typedef struct packed {
    logic     ovf;
    pe_wide_t val;
  } pe_sat_t;

  // Sign-extend the low w bits of x to the full working width.
  function automatic pe_wide_t sext(input pe_wide_t x, input int unsigned w);
    pe_wide_t t;
    t = x <<< (PE_MAXW - w);
    return t >>> (PE_MAXW - w);
  endfunction

  // a + b clamped to the signed range of a w-bit value (w < PE_MAXW).
  // Operands must already be sign-extended from w bits.
  function automatic pe_sat_t sat_add(input pe_wide_t a, input pe_wide_t b,
                                      input int unsigned w);
    logic signed [PE_MAXW:0] s;
    logic signed [PE_MAXW:0] one;
    logic signed [PE_MAXW:0] hi;
    logic signed [PE_MAXW:0] lo;
    pe_sat_t r;
    one    = '0;
    one[0] = 1'b1;
    s      = {a[PE_MAXW-1], a} + {b[PE_MAXW-1], b};
    hi     = (one <<< (w - 1)) - one;
    lo     = -hi - one;
    r.ovf  = 1'b0;
    r.val  = s[PE_MAXW-1:0];
    if (s > hi) begin
      r.ovf = 1'b1;
      r.val = hi[PE_MAXW-1:0];
    end else if (s < lo) begin
      r.ovf = 1'b1;
      r.val = lo[PE_MAXW-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_result_fifo.sv
// Small synchronous result queue. The head entry is read straight from the
// storage flops, so a pushed entry becomes visible one cycle after the push
// and never falls through combinationally.
// Handshake: an entry leaves when pop is asserted while the queue is non-empty;
// the caller only asserts push when !full or when a pop happens that cycle.
module pe_result_fifo #(
  parameter int DATA_W = 41,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_rd;
  logic [PW-1:0]     r_wr;
  logic [CW-1:0]     r_count;
  logic              w_pop;

  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));
  assign head  = r_mem[r_rd];
  assign w_pop = pop && !empty;

  // Storage, pointers and occupancy; simultaneous push and pop keep the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (push) begin
        r_mem[r_wr] <= push_data;
        r_wr        <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
      end
      if (w_pop) r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
      case ({push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pe_accumulator.sv
// Dot-product reduction: sums every VEC_LEN valid samples with saturation and
// queues each result behind a valid/ready port. The input never stalls; a
// result that finds the queue full (and not draining) is dropped and flagged.
// Output handshake: a result transfers on a cycle where out_valid && out_ready;
// while out_valid && !out_ready, out_data and out_sat hold stable.
module pe_accumulator
  import pe_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = PE_ACC_WIDTH,
  parameter int VEC_LEN   = 8,
  parameter int OUT_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_sat,
  output logic                 busy,
  output logic                 drop_err
);

  localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

  logic [CNT_W-1:0]     r_cnt;
  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_sat;
  logic                 r_busy;
  logic                 r_drop;

  pe_wide_t             w_in_wide;
  pe_wide_t             w_acc_wide;
  pe_sat_t              w_sum;
  logic                 w_first;
  logic                 w_fire;
  logic                 w_last;
  logic [ACC_WIDTH-1:0] w_res_data;
  logic                 w_res_sat;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_full;
  logic                 w_empty;
  logic [ACC_WIDTH:0]   w_head;
  logic                 w_unused;

  // Running sum arithmetic and vector bookkeeping for the current sample.
  always_comb begin
    w_in_wide  = sext(pe_wide_t'(in_data), IN_WIDTH);
    w_acc_wide = sext(pe_wide_t'(r_acc), ACC_WIDTH);
    w_sum      = sat_add(w_acc_wide, w_in_wide, ACC_WIDTH);
    w_first    = (r_cnt == '0);
    w_fire     = in_valid && !clear;
    w_last     = w_fire && (r_cnt == CNT_W'(VEC_LEN - 1));
    // A fresh vector starts from the sample itself, so it cannot saturate.
    w_res_data = w_first ? w_in_wide[ACC_WIDTH-1:0] : w_sum.val[ACC_WIDTH-1:0];
    w_res_sat  = w_first ? 1'b0 : (r_sat | w_sum.ovf);
    w_cnt_nxt  = r_cnt;
    if (clear)       w_cnt_nxt = '0;
    else if (in_valid) w_cnt_nxt = w_last ? '0 : r_cnt + 1'b1;
  end

  assign w_unused = ^{w_in_wide, w_sum.val};

  // Queue admission: a full queue only takes a result if it drains this cycle.
  assign w_pop  = out_valid && out_ready;
  assign w_drop = w_last && w_full && !w_pop;
  assign w_push = w_last && !w_drop;

  // Counter, accumulator, per-vector saturation flag and sticky drop error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_acc  <= '0;
      r_sat  <= 1'b0;
      r_busy <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      if (clear) begin
        r_acc <= '0;
        r_sat <= 1'b0;
      end else if (in_valid) begin
        r_acc <= w_res_data;
        r_sat <= w_res_sat;
      end
      r_cnt  <= w_cnt_nxt;
      r_busy <= (w_cnt_nxt != '0);
      if (w_drop) r_drop <= 1'b1;
    end
  end

  pe_result_fifo #(
    .DATA_W (ACC_WIDTH + 1),
    .DEPTH  (OUT_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data ({w_res_sat, w_res_data}),
    .pop       (w_pop),
    .full      (w_full),
    .empty     (w_empty),
    .head      (w_head)
  );

  assign out_valid = !w_empty;
  assign out_sat   = w_head[ACC_WIDTH];
  assign out_data  = w_head[ACC_WIDTH-1:0];
  assign busy      = r_busy;
  assign drop_err  = r_drop;

endmodule

// File: tb/tb_pe_accumulator.sv
// Bench for pe_accumulator (ACC_WIDTH=17, VEC_LEN=4, OUT_DEPTH=2): directed
// vector table, hand-written queue/clear/reset sequences, and random traffic
// checked against a vector-level reference model.
module tb_pe_accumulator;

  localparam int IN_W  = 16;
  localparam int ACC_W = 17;
  localparam int VLEN  = 4;
  localparam int DEPTH = 2;
  localparam int W     = ACC_W + 1;
  localparam longint MAXV = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint MINV = -MAXV - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic [IN_W-1:0]  in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_data;
  logic             out_sat;
  logic             busy;
  logic             drop_err;

  int n_cmp  = 0;
  int n_fail = 0;

  // clock / reset block
  always #5 clk = ~clk;

  pe_accumulator #(
    .IN_WIDTH  (IN_W),
    .ACC_WIDTH (ACC_W),
    .VEC_LEN   (VLEN),
    .OUT_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .busy      (busy),
    .drop_err  (drop_err)
  );

  // reference model: samples of the open vector, queued results {sat,data}
  longint     cur_vec[$];
  logic [W-1:0] exp_q[$];
  logic       m_drop = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] fold_vector();
    longint acc;
    logic   sat;
    logic [63:0] a64;
    acc = cur_vec[0];
    sat = 1'b0;
    for (int i = 1; i < cur_vec.size(); i++) begin
      acc = acc + cur_vec[i];
      if (acc > MAXV) begin acc = MAXV; sat = 1'b1; end
      if (acc < MINV) begin acc = MINV; sat = 1'b1; end
    end
    a64 = acc;
    return {sat, a64[ACC_W-1:0]};
  endfunction

  function automatic void model_reset();
    cur_vec.delete();
    exp_q.delete();
    m_drop = 1'b0;
  endfunction

  function automatic void model_cycle(input logic v, input logic [IN_W-1:0] d,
                                      input logic clr, input logic rdy);
    logic         pop;
    logic         done;
    logic [W-1:0] res;
    pop  = (exp_q.size() != 0) && rdy;
    done = 1'b0;
    res  = '0;
    if (clr) cur_vec.delete();
    else if (v) begin
      cur_vec.push_back(longint'($signed(d)));
      if (cur_vec.size() == VLEN) begin
        res  = fold_vector();
        done = 1'b1;
        cur_vec.delete();
      end
    end
    if (pop) void'(exp_q.pop_front());
    if (done) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(res);
      else m_drop = 1'b1;
    end
  endfunction

  task automatic model_check();
    check("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("out_data", out_data, exp_q[0][ACC_W-1:0]);
      check("out_sat", out_sat, exp_q[0][ACC_W]);
    end
    check("busy", busy, cur_vec.size() != 0);
    check("drop_err", drop_err, m_drop);
  endtask

  // driver: apply one cycle of inputs at negedge, check after the next posedge
  task automatic step(input logic v, input logic [IN_W-1:0] d,
                      input logic clr, input logic rdy);
    in_valid  = v;
    in_data   = d;
    clear     = clr;
    out_ready = rdy;
    model_cycle(v, d, clr, rdy);
    @(posedge clk);
    @(negedge clk);
    model_check();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; clear = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst out_valid", out_valid, 1'b0);
    check("rst out_data", out_data, '0);
    check("rst out_sat", out_sat, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst drop_err", drop_err, 1'b0);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic send_vec(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b,
                          input logic [IN_W-1:0] c, input logic [IN_W-1:0] e,
                          input logic rdy_last);
    step(1'b1, a, 1'b0, 1'b0);
    step(1'b1, b, 1'b0, 1'b0);
    step(1'b1, c, 1'b0, 1'b0);
    step(1'b1, e, 1'b0, rdy_last);
  endtask

  typedef struct {
    logic             v;
    logic [IN_W-1:0]  d;
    logic             ev;
    logic [ACC_W-1:0] ed;
    logic             es;
    logic             eb;
  } row_t;

  row_t tbl[$];

  function automatic row_t mk(input logic v, input logic [IN_W-1:0] d, input logic ev,
                              input logic [ACC_W-1:0] ed, input logic es, input logic eb);
    row_t r;
    r.v = v; r.d = d; r.ev = ev; r.ed = ed; r.es = es; r.eb = eb;
    return r;
  endfunction

  initial begin
    // directed table, out_ready=1 throughout: {valid, data, exp valid, data, sat, busy}
    tbl.push_back(mk(1, 16'd1,    0, 17'h0,     0, 1));
    tbl.push_back(mk(1, 16'd2,    0, 17'h0,     0, 1));
    tbl.push_back(mk(1, 16'd3,    0, 17'h0,     0, 1));
    tbl.push_back(mk(1, 16'd4,    1, 17'd10,    0, 0));
    tbl.push_back(mk(0, 16'd0,    0, 17'h0,     0, 0));
    tbl.push_back(mk(1, 16'hFFFB, 0, 17'h0,     0, 1));
    tbl.push_back(mk(1, 16'd7,    0, 17'h0,     0, 1));
    tbl.push_back(mk(0, 16'd0,    0, 17'h0,     0, 1));
    tbl.push_back(mk(0, 16'd0,    0, 17'h0,     0, 1));
    tbl.push_back(mk(1, 16'hFF9C, 0, 17'h0,     0, 1));
    tbl.push_back(mk(1, 16'd3,    1, 17'h1FFA1, 0, 0));
    tbl.push_back(mk(0, 16'd0,    0, 17'h0,     0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 16'h7FFF, 0, 17'h0, 0, 1));
    tbl.push_back(mk(1, 16'h7FFF, 1, 17'h0FFFF, 1, 0));
    tbl.push_back(mk(0, 16'd0,    0, 17'h0,     0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 16'h8000, 0, 17'h0, 0, 1));
    tbl.push_back(mk(1, 16'h8000, 1, 17'h10000, 1, 0));
    tbl.push_back(mk(0, 16'd0,    0, 17'h0,     0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 16'd1, 0, 17'h0, 0, 1));
    tbl.push_back(mk(1, 16'd1,    1, 17'd4,     0, 0));
    tbl.push_back(mk(0, 16'd0,    0, 17'h0,     0, 0));

    @(negedge clk);
    do_reset();

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d, 1'b0, 1'b1);
      check($sformatf("tbl[%0d] out_valid", i), out_valid, tbl[i].ev);
      check($sformatf("tbl[%0d] busy", i), busy, tbl[i].eb);
      if (tbl[i].ev) begin
        check($sformatf("tbl[%0d] out_data", i), out_data, tbl[i].ed);
        check($sformatf("tbl[%0d] out_sat", i), out_sat, tbl[i].es);
      end
    end

    // queue overrun: third result dropped while downstream is stalled
    do_reset();
    send_vec(16'd1, 16'd2, 16'd3, 16'd4, 1'b0);
    send_vec(16'd2, 16'd4, 16'd6, 16'd8, 1'b0);
    send_vec(16'd5, 16'd5, 16'd10, 16'd10, 1'b0);
    check("ovr drop_err", drop_err, 1'b1);
    check("ovr head0", out_data, 17'd10);
    step(1'b0, '0, 1'b0, 1'b1);
    check("ovr head1", out_data, 17'd20);
    step(1'b0, '0, 1'b0, 1'b1);
    check("ovr drained", out_valid, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("ovr drop sticky", drop_err, 1'b1);

    // full queue but draining on the completing cycle: no drop
    do_reset();
    send_vec(16'd1, 16'd2, 16'd3, 16'd4, 1'b0);
    send_vec(16'd2, 16'd4, 16'd6, 16'd8, 1'b0);
    send_vec(16'd5, 16'd5, 16'd10, 16'd10, 1'b1);
    check("drain drop_err", drop_err, 1'b0);
    check("drain head1", out_data, 17'd20);
    step(1'b0, '0, 1'b0, 1'b1);
    check("drain head2", out_data, 17'd30);
    step(1'b0, '0, 1'b0, 1'b1);
    check("drain empty", out_valid, 1'b0);

    // clear beats a same-cycle sample and aborts the partial vector
    step(1'b1, 16'd1, 1'b0, 1'b1);
    step(1'b1, 16'd2, 1'b0, 1'b1);
    step(1'b1, 16'd9, 1'b1, 1'b1);
    check("clear busy", busy, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 16'd1, 1'b0, 1'b0);
    check("clear result", out_data, 17'd4);
    check("clear valid", out_valid, 1'b1);

    // reset with a queued result discards it
    do_reset();
    step(1'b0, '0, 1'b0, 1'b1);
    check("rst lost", out_valid, 1'b0);

    // randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      logic [IN_W-1:0] d;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel == 0) d = 16'h7FFF;
      else if (sel == 1) d = 16'h8000;
      else d = IN_W'($urandom);
      step($urandom_range(0, 9) < 7, d, $urandom_range(0, 39) == 0,
           $urandom_range(0, 9) < 5);
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
